max7219_writer: RTL and testbench

- Responder side of the display strobe/acknowledge handshake.
- On an accepted request, serializes either the MAX7219 configuration sequence or the six clock-digit registers as 16-bit SPI frames.
- Pulses an acknowledge when the last frame is latched.
- Sits between the display controller and the MAX7219 pins.

---
 rtl/max7219_pkg.sv | 64 ++++++
 rtl/max7219_writer_spi_frame_tx.sv | 132 +++++++++++++
 rtl/max7219_writer.sv | 126 ++++++++++++
 tb/tb_max7219_writer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared constants, state encodings and the frame-word builder for the MAX7219 writer.
package max7219_pkg;

    localparam int FRAME_BITS   = 16;
    localparam int CONFIG_WORDS = 5;
    localparam int DIGIT_WORDS  = 6;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    localparam logic [7:0] REG_DIGIT0    = 8'h01;
    localparam logic [7:0] REG_DIGIT1    = 8'h02;
    localparam logic [7:0] REG_DIGIT2    = 8'h03;
    localparam logic [7:0] REG_DIGIT3    = 8'h04;
    localparam logic [7:0] REG_DIGIT4    = 8'h05;
    localparam logic [7:0] REG_DIGIT5    = 8'h06;
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    typedef enum logic [1:0] {SEQ_IDLE, SEQ_FRAME, SEQ_GAP, SEQ_DONE} seq_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_FRAME, TX_GAP} tx_state_t;

    // Word idx of either the config sequence or the digit sequence; a zero hours-tens digit is blanked.
    function automatic logic [15:0] build_word(input logic cfg, input logic [23:0] bcd,
                                               input logic [3:0] inten, input logic [2:0] idx);
        logic [15:0] word;
        logic [23:0] sh;
        logic [3:0]  nib;
        logic [7:0]  addr;
        word = 16'h0000;
        sh   = bcd >> {idx, 2'b00};
        nib  = sh[3:0];
        addr = 8'h00;
        if (cfg) begin
            case (idx)
                3'd0:    word = {REG_SHUTDOWN, 8'h01};
                3'd1:    word = {REG_DECODE, 8'hFF};
                3'd2:    word = {REG_INTENSITY, 4'h0, inten};
                3'd3:    word = {REG_SCANLIMIT, 8'h05};
                3'd4:    word = {REG_TEST, 8'h00};
                default: word = 16'h0000;
            endcase
        end else begin
            case (idx)
                3'd0:    addr = REG_DIGIT0;
                3'd1:    addr = REG_DIGIT1;
                3'd2:    addr = REG_DIGIT2;
                3'd3:    addr = REG_DIGIT3;
                3'd4:    addr = REG_DIGIT4;
                3'd5:    addr = REG_DIGIT5;
                default: addr = 8'h00;
            endcase
            if ((idx == 3'd5) && (nib == 4'h0)) begin
                nib = BLANK_CODE;
            end else begin
                nib = sh[3:0];
            end
            word = {addr, 4'h0, nib};
        end
        return word;
    endfunction

endpackage

// File: rtl/max7219_writer_spi_frame_tx.sv
// One 16-bit SPI frame (MSB first, SCK idle low) followed by a CS_n-high gap; back-to-back
// frames chain when i_start coincides with o_done.
module spi_frame_tx
    import max7219_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [FRAME_BITS-1:0] i_word,
    output logic                  o_cs_n,
    output logic                  o_sck,
    output logic                  o_dout,
    output logic                  o_frame_done,
    output logic                  o_done
);

    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

    tx_state_t       state_r, state_s;
    logic [HW-1:0]   half_cnt_r, half_cnt_s;
    logic [3:0]      bit_cnt_r, bit_cnt_s;
    logic [15:0]     shift_r, shift_s;
    logic            tail_r, tail_s;
    logic            gap_hi_r, gap_hi_s;
    logic            sck_r, sck_s;
    logic            cs_n_r, cs_n_s;
    logic            dout_r, dout_s;
    logic            half_end_s;
    logic            load_s;

    assign half_end_s   = (half_cnt_r == HALF_LAST);
    assign o_frame_done = (state_r == TX_FRAME) && tail_r && half_end_s;
    assign o_done       = (state_r == TX_GAP) && gap_hi_r && half_end_s;
    assign load_s       = i_start && ((state_r == TX_IDLE) || o_done);
    assign o_cs_n       = cs_n_r;
    assign o_sck        = sck_r;
    assign o_dout       = dout_r;

    // Next-state and next-output logic for the frame/gap timing.
    always_comb begin
        state_s    = state_r;
        half_cnt_s = half_end_s ? '0 : half_cnt_r + HW'(1);
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        tail_s     = tail_r;
        gap_hi_s   = gap_hi_r;
        sck_s      = sck_r;
        cs_n_s     = cs_n_r;
        dout_s     = dout_r;
        case (state_r)
            TX_IDLE: begin
                half_cnt_s = '0;
            end
            TX_FRAME: begin
                if (!half_end_s) begin
                    sck_s = sck_r;
                end else if (tail_r) begin
                    state_s  = TX_GAP;
                    cs_n_s   = 1'b1;
                    dout_s   = 1'b0;
                    gap_hi_s = 1'b0;
                end else if (!sck_r) begin
                    sck_s = 1'b1;
                end else begin
                    // Falling SCK: the next bit appears at the start of the low phase.
                    sck_s   = 1'b0;
                    dout_s  = shift_r[15];
                    shift_s = {shift_r[14:0], 1'b0};
                    if (bit_cnt_r == 4'(FRAME_BITS - 1)) begin
                        tail_s = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end
            end
            TX_GAP: begin
                if (!half_end_s) begin
                    gap_hi_s = gap_hi_r;
                end else if (gap_hi_r) begin
                    state_s = TX_IDLE;
                end else begin
                    gap_hi_s = 1'b1;
                end
            end
            default: begin
                state_s = TX_IDLE;
            end
        endcase
        if (load_s) begin
            state_s    = TX_FRAME;
            half_cnt_s = '0;
            bit_cnt_s  = 4'd0;
            tail_s     = 1'b0;
            gap_hi_s   = 1'b0;
            cs_n_s     = 1'b0;
            sck_s      = 1'b0;
            dout_s     = i_word[15];
            shift_s    = {i_word[14:0], 1'b0};
        end else begin
            cs_n_s = cs_n_s;
        end
    end

    // State and registered pin drivers; reset drops any frame in progress.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r    <= TX_IDLE;
            half_cnt_r <= '0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 16'h0000;
            tail_r     <= 1'b0;
            gap_hi_r   <= 1'b0;
            sck_r      <= 1'b0;
            cs_n_r     <= 1'b1;
            dout_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            half_cnt_r <= half_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            tail_r     <= tail_s;
            gap_hi_r   <= gap_hi_s;
            sck_r      <= sck_s;
            cs_n_r     <= cs_n_s;
            dout_r     <= dout_s;
        end
    end

endmodule

// File: rtl/max7219_writer.sv
// Strobe/ack responder that sends the MAX7219 config sequence or the six clock digits
// as a burst of SPI frames, acknowledging once the last frame has been latched.
module max7219_writer
    import max7219_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_display_stb,
    input  logic        i_write_config,
    output logic        o_display_ack,
    input  logic [23:0] i_time_bcd,
    input  logic [3:0]  i_intensity,
    output logic        o_busy,
    output logic        o_serial_cs_n,
    output logic        o_serial_clk,
    output logic        o_serial_dout
);

    seq_state_t  state_r, state_s;
    logic        cfg_r;
    logic [23:0] bcd_r;
    logic [3:0]  inten_r;
    logic [2:0]  idx_r;
    logic        ack_r;
    logic        busy_r;
    logic        start_s;
    logic        accept_s;
    logic        advance_s;
    logic        last_s;
    logic [15:0] word_s;
    logic        tx_frame_done_s;
    logic        tx_done_s;

    assign last_s = cfg_r ? (idx_r == 3'(CONFIG_WORDS - 1)) : (idx_r == 3'(DIGIT_WORDS - 1));
    assign o_display_ack = ack_r;
    assign o_busy        = busy_r;

    // Sequencer: the first word comes from the live inputs so CS_n can fall right after accept.
    always_comb begin
        state_s   = state_r;
        start_s   = 1'b0;
        accept_s  = 1'b0;
        advance_s = 1'b0;
        word_s    = build_word(cfg_r, bcd_r, inten_r, idx_r + 3'd1);
        case (state_r)
            SEQ_IDLE: begin
                word_s = build_word(i_write_config, i_time_bcd, i_intensity, 3'd0);
                if (i_display_stb) begin
                    state_s  = SEQ_FRAME;
                    start_s  = 1'b1;
                    accept_s = 1'b1;
                end else begin
                    state_s = SEQ_IDLE;
                end
            end
            SEQ_FRAME: begin
                if (tx_frame_done_s) begin
                    state_s = SEQ_GAP;
                end else begin
                    state_s = SEQ_FRAME;
                end
            end
            SEQ_GAP: begin
                if (!tx_done_s) begin
                    state_s = SEQ_GAP;
                end else if (last_s) begin
                    state_s = SEQ_DONE;
                end else begin
                    state_s   = SEQ_FRAME;
                    start_s   = 1'b1;
                    advance_s = 1'b1;
                end
            end
            SEQ_DONE: begin
                state_s = SEQ_IDLE;
            end
            default: begin
                state_s = SEQ_IDLE;
            end
        endcase
    end

    // Request latch, word index and registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r <= SEQ_IDLE;
            cfg_r   <= 1'b0;
            bcd_r   <= 24'h000000;
            inten_r <= 4'h0;
            idx_r   <= 3'd0;
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ack_r   <= (state_s == SEQ_DONE);
            busy_r  <= (state_s != SEQ_IDLE);
            if (accept_s) begin
                cfg_r   <= i_write_config;
                bcd_r   <= i_time_bcd;
                inten_r <= i_intensity;
                idx_r   <= 3'd0;
            end else if (advance_s) begin
                idx_r <= idx_r + 3'd1;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    spi_frame_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_start      (start_s),
        .i_word       (word_s),
        .o_cs_n       (o_serial_cs_n),
        .o_sck        (o_serial_clk),
        .o_dout       (o_serial_dout),
        .o_frame_done (tx_frame_done_s),
        .o_done       (tx_done_s)
    );

endmodule

// File: tb/tb_max7219_writer.sv
// Directed bench: three writers (CLK_DIV 1, 2, 3) with a per-instance SPI frame decoder.
module tb_max7219_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  stb_v;
    logic        cfg;
    logic [23:0] bcd;
    logic [3:0]  inten;
    logic        mon_clr;
    logic [2:0]  ack_v, busy_v, cs_v, sck_v, dout_v;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_b [23];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    max7219_writer #(.CLK_DIV(1)) dut_t1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_display_stb(stb_v[0]), .i_write_config(cfg),
        .o_display_ack(ack_v[0]), .i_time_bcd(bcd), .i_intensity(inten), .o_busy(busy_v[0]),
        .o_serial_cs_n(cs_v[0]), .o_serial_clk(sck_v[0]), .o_serial_dout(dout_v[0]));
    max7219_writer #(.CLK_DIV(2)) dut_t2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_display_stb(stb_v[1]), .i_write_config(cfg),
        .o_display_ack(ack_v[1]), .i_time_bcd(bcd), .i_intensity(inten), .o_busy(busy_v[1]),
        .o_serial_cs_n(cs_v[1]), .o_serial_clk(sck_v[1]), .o_serial_dout(dout_v[1]));
    max7219_writer #(.CLK_DIV(3)) dut_t3 (
        .i_clk(clk), .i_reset_n(rst_n), .i_display_stb(stb_v[2]), .i_write_config(cfg),
        .o_display_ack(ack_v[2]), .i_time_bcd(bcd), .i_intensity(inten), .o_busy(busy_v[2]),
        .o_serial_cs_n(cs_v[2]), .o_serial_clk(sck_v[2]), .o_serial_dout(dout_v[2]));

    // Frame decoder per instance: shifts DIN on SCK rise while CS_n low, records word at CS_n rise.
    for (genvar g = 0; g < 3; g++) begin : mon
        logic        prev_cs, prev_sck, prev_dout;
        logic [15:0] shreg;
        int          edges, hi_cnt, gap_min, frame_cnt, ack_cnt, ack_first;
        bit          seen, bad_stable;
        logic [15:0] frames [32];
        int          frame_edges [32];
        always @(negedge clk) begin
            if (mon_clr) begin
                frame_cnt <= 0; ack_cnt <= 0; ack_first <= -1; seen <= 1'b0;
                bad_stable <= 1'b0; gap_min <= 1000; hi_cnt <= 0; edges <= 0; shreg <= 16'h0000;
            end else begin
                if (ack_v[g]) begin
                    ack_cnt <= ack_cnt + 1;
                    if (ack_cnt == 0) ack_first <= cyc;
                end
                if (!cs_v[g]) begin
                    if (prev_cs) begin
                        if (seen && hi_cnt < gap_min) gap_min <= hi_cnt;
                        shreg <= 16'h0000;
                        edges <= 0;
                    end else if (sck_v[g] && !prev_sck) begin
                        shreg <= {shreg[14:0], dout_v[g]};
                        edges <= edges + 1;
                    end
                    if (sck_v[g] && (dout_v[g] !== prev_dout)) bad_stable <= 1'b1;
                end else begin
                    if (!prev_cs && frame_cnt < 32) begin
                        frames[frame_cnt]      <= shreg;
                        frame_edges[frame_cnt] <= edges;
                        frame_cnt <= frame_cnt + 1;
                        seen <= 1'b1;
                    end
                    hi_cnt <= (!prev_cs) ? 1 : hi_cnt + 1;
                end
            end
            prev_cs   <= cs_v[g];
            prev_sck  <= sck_v[g];
            prev_dout <= dout_v[g];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Waits (bounded) for the CLK_DIV=2 ack, counting cycles where busy was low meanwhile.
    task automatic wait_ack(output bit ok, output int busy_low);
        ok = 1'b0;
        busy_low = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy_v[1]) busy_low++;
            if (ack_v[1]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int blo, t0, t_ack, p1;
        exp_b = '{16'h0C01, 16'h09FF, 16'h0A07, 16'h0B05, 16'h0F00,
                  16'h0106, 16'h0205, 16'h0304, 16'h0403, 16'h0502, 16'h0601,
                  16'h0100, 16'h0200, 16'h0305, 16'h0400, 16'h0509, 16'h060F,
                  16'h0000,
                  16'h0C01, 16'h09FF, 16'h0A03, 16'h0B05, 16'h0F00};
        rst_n = 1'b0; stb_v = 3'b000; cfg = 1'b0; bcd = 24'h0; inten = 4'h0; mon_clr = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_cs_n", {29'd0, cs_v}, 32'h7);
        chk("reset_sck", {29'd0, sck_v}, 32'h0);
        chk("reset_dout", {29'd0, dout_v}, 32'h0);
        chk("reset_ack", {29'd0, ack_v}, 32'h0);
        chk("reset_busy", {29'd0, busy_v}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;

        // Config on all three; CLK_DIV=2 keeps its strobe high.
        cfg = 1'b1; inten = 4'h7; bcd = 24'h123456; stb_v = 3'b111; t0 = cyc; p1 = cyc;
        @(negedge clk);
        stb_v[0] = 1'b0; stb_v[2] = 1'b0;
        chk("busy_after_accept", {31'd0, busy_v[1]}, 32'h1);
        wait_ack(ok, blo);
        t_ack = cyc;
        chk("cfg_ack_seen", {31'd0, ok}, 32'h1);
        chk("cfg_ack_cycle", t_ack, t0 + 351);
        chk("cfg_busy_low", blo, 0);

        // Strobe still high: digit burst 12:34:56 accepted in the idle cycle after ack.
        cfg = 1'b0; bcd = 24'h123456;
        @(negedge clk);
        chk("idle_after_ack_busy", {31'd0, busy_v[1]}, 32'h0);
        chk("ack_single_cycle", {31'd0, ack_v[1]}, 32'h0);
        @(negedge clk);
        stb_v[1] = 1'b0;
        chk("busy_digits", {31'd0, busy_v[1]}, 32'h1);
        repeat (40) @(negedge clk);
        bcd = 24'h999999; stb_v[1] = 1'b1;
        @(negedge clk);
        stb_v[1] = 1'b0; cfg = 1'b1;
        repeat (100) @(negedge clk);
        stb_v[1] = 1'b1;
        @(negedge clk);
        stb_v[1] = 1'b0;
        wait_ack(ok, blo);
        chk("dig_ack_cycle", cyc, t_ack + 422);
        chk("dig_busy_low", blo, 0);
        repeat (20) @(negedge clk);
        chk("dig_no_extra_frames", mon[1].frame_cnt, 11);
        chk("dig_ack_count", mon[1].ack_cnt, 2);
        chk("dig_idle_busy", {31'd0, busy_v[1]}, 32'h0);

        // 09:05:00 with a one-cycle strobe.
        cfg = 1'b0; bcd = 24'h090500; stb_v[1] = 1'b1; t0 = cyc;
        @(negedge clk);
        stb_v[1] = 1'b0;
        wait_ack(ok, blo);
        chk("blank_ack_cycle", cyc, t0 + 421);
        repeat (10) @(negedge clk);

        // Reset in the middle of the first frame.
        cfg = 1'b1; inten = 4'h3; stb_v[1] = 1'b1; t0 = cyc;
        @(negedge clk);
        stb_v[1] = 1'b0;
        repeat (33) @(negedge clk);
        chk("midframe_cs_low", {31'd0, cs_v[1]}, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", {31'd0, cs_v[1]}, 32'h1);
        chk("abort_sck", {31'd0, sck_v[1]}, 32'h0);
        chk("abort_dout", {31'd0, dout_v[1]}, 32'h0);
        chk("abort_busy", {31'd0, busy_v[1]}, 32'h0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("abort_no_ack", mon[1].ack_cnt, 3);
        chk("abort_idle_cs", {31'd0, cs_v[1]}, 32'h1);
        chk("abort_frame_count", mon[1].frame_cnt, 18);

        // Fresh config after the abort.
        stb_v[1] = 1'b1; t0 = cyc;
        @(negedge clk);
        stb_v[1] = 1'b0;
        wait_ack(ok, blo);
        chk("recover_ack_cycle", cyc, t0 + 351);
        repeat (20) @(negedge clk);
        chk("recover_ack_count", mon[1].ack_cnt, 4);
        chk("recover_frame_count", mon[1].frame_cnt, 23);

        for (int k = 0; k < 23; k++) begin
            if (k != 17) begin
                chk($sformatf("t2_word%0d", k), {16'd0, mon[1].frames[k]}, {16'd0, exp_b[k]});
                chk($sformatf("t2_edges%0d", k), mon[1].frame_edges[k], 16);
            end
        end
        chk("t2_dout_stable", {31'd0, mon[1].bad_stable}, 32'h0);
        chk("t2_gap", {31'd0, (mon[1].gap_min >= 4)}, 32'h1);

        // CLK_DIV=1 and CLK_DIV=3 config bursts from the first phase.
        chk("t1_frames", mon[0].frame_cnt, 5);
        chk("t3_frames", mon[2].frame_cnt, 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t1_word%0d", k), {16'd0, mon[0].frames[k]}, {16'd0, exp_b[k]});
            chk($sformatf("t1_edges%0d", k), mon[0].frame_edges[k], 16);
            chk($sformatf("t3_word%0d", k), {16'd0, mon[2].frames[k]}, {16'd0, exp_b[k]});
            chk($sformatf("t3_edges%0d", k), mon[2].frame_edges[k], 16);
        end
        chk("t1_dout_stable", {31'd0, mon[0].bad_stable}, 32'h0);
        chk("t3_dout_stable", {31'd0, mon[2].bad_stable}, 32'h0);
        chk("t1_gap", {31'd0, (mon[0].gap_min >= 2)}, 32'h1);
        chk("t3_gap", {31'd0, (mon[2].gap_min >= 6)}, 32'h1);
        chk("t1_ack_cycle", mon[0].ack_first, p1 + 176);
        chk("t3_ack_cycle", mon[2].ack_first, p1 + 526);
        chk("t1_ack_count", mon[0].ack_cnt, 1);
        chk("t3_ack_count", mon[2].ack_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
